sample_checker: RTL and testbench

//  Response-side counterpart to the sample stimulus bench: consumes expected vectors and DUT observed outputs
//  (D,E), compares in order, counts mismatches and reports pass/fail. Synthesisable, so it serves as a sim

---
 rtl/sample_chk_pkg.sv | 19 +
 rtl/sample_chk_fifo.sv | 65 ++++++
 rtl/sample_checker.sv | 139 +++++++++++++
 tb/tb_sample_checker.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_chk_pkg.sv
// Shared types and helpers for the sample checker: FSM state encoding and sizing functions.
package sample_chk_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } chk_state_e;

    // Pointer width carries one extra MSB so full and empty can be told apart.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [31:0] all_ones(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/sample_chk_fifo.sv
// Expected-vector FIFO: DEPTH x DATA_W, synchronous push/pop with flush and simultaneous push+pop when full.
module sample_chk_fifo
    import sample_chk_pkg::*;
#(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PtrW = ptr_w(DEPTH);
    localparam int unsigned AddrW = PtrW - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic              do_push;
    logic              do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    assign rdata = mem[rptr_q[AddrW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: contents are only read through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr_q[AddrW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/sample_checker.sv
// In-order response checker: buffers expected vectors, compares against observed DUT vectors, reports result.
module sample_checker
    import sample_chk_pkg::*;
#(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vectors,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              obs_valid,
    input  logic [DATA_W-1:0] obs_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err,
    output logic              underflow
);

    localparam logic [CNT_W-1:0] CntOnes = CNT_W'(all_ones(CNT_W));

    chk_state_e        state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  first_q, first_d;
    logic              uf_q, uf_d;
    logic              pass_q, pass_d;
    logic              busy_q, done_q;

    logic              fifo_full, fifo_empty, fifo_flush, fifo_pop, fifo_push;
    logic [DATA_W-1:0] fifo_rdata;
    logic              err_hit;

    assign exp_ready = (state_q == StRun) && (!fifo_full || obs_valid);
    assign fifo_push = exp_valid && exp_ready;

    sample_chk_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (exp_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        idx_d      = idx_q;
        err_d      = err_q;
        first_d    = first_q;
        uf_d       = uf_q;
        pass_d     = pass_q;
        fifo_flush = 1'b0;
        fifo_pop   = 1'b0;
        err_hit    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    fifo_flush = 1'b1;
                    num_d      = num_vectors;
                    idx_d      = '0;
                    err_d      = '0;
                    first_d    = CntOnes;
                    uf_d       = 1'b0;
                    pass_d     = (num_vectors == '0);
                    state_d    = (num_vectors == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (obs_valid) begin
                    idx_d = idx_q + 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        err_hit  = (fifo_rdata != obs_data);
                    end else begin
                        uf_d    = 1'b1;
                        err_hit = 1'b1;
                    end
                    if (err_hit) begin
                        if (err_q != CntOnes) err_d = err_q + 1'b1;
                        // A zero count means no earlier error in this run.
                        if (err_q == '0) first_d = idx_q;
                    end
                    if (idx_q == num_q - 1'b1) begin
                        state_d = StDone;
                        pass_d  = !err_hit && (err_q == '0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            num_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            first_q <= CntOnes;
            uf_q    <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            first_q <= first_d;
            uf_q    <= uf_d;
            pass_q  <= pass_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign first_err = first_q;
    assign underflow = uf_q;

endmodule

// File: tb/tb_sample_checker.sv
// Self-checking bench for sample_checker: directed scenarios plus randomized runs against a queue-based model.
module tb_sample_checker;

    localparam int DATA_W = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MDone = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  num_vectors;
    logic              exp_valid;
    logic              exp_ready;
    logic [DATA_W-1:0] exp_data;
    logic              obs_valid;
    logic [DATA_W-1:0] obs_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  first_err;
    logic              underflow;

    int checks;
    int errors;

    // Behavioural model state
    int         m_mode;
    logic [1:0] m_q[$];
    int         m_num;
    int         m_idx;
    int         m_err;
    int         m_first;
    bit         m_uf;

    sample_checker #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_vectors (num_vectors),
        .exp_valid   (exp_valid),
        .exp_ready   (exp_ready),
        .exp_data    (exp_data),
        .obs_valid   (obs_valid),
        .obs_data    (obs_data),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count),
        .first_err   (first_err),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = MIdle;
        m_q.delete();
        m_num   = 0;
        m_idx   = 0;
        m_err   = 0;
        m_first = 255;
        m_uf    = 0;
    endtask

    function automatic bit model_ready();
        return (m_mode == MRun) && ((m_q.size() < DEPTH) || obs_valid);
    endfunction

    task automatic model_update();
        bit         rdy;
        bit         bad;
        logic [1:0] head;
        rdy = model_ready();
        bad = 0;
        if (m_mode == MRun) begin
            if (obs_valid) begin
                if (m_q.size() > 0) begin
                    head = m_q.pop_front();
                    bad  = (head != obs_data);
                end else begin
                    m_uf = 1;
                    bad  = 1;
                end
                if (bad) begin
                    if (m_err == 0) m_first = m_idx;
                    if (m_err < 255) m_err++;
                end
                m_idx++;
                if (m_idx == m_num) m_mode = MDone;
            end
            if (exp_valid && rdy) m_q.push_back(exp_data);
        end else if (start) begin
            m_q.delete();
            m_num   = int'(num_vectors);
            m_idx   = 0;
            m_err   = 0;
            m_first = 255;
            m_uf    = 0;
            m_mode  = (num_vectors == 0) ? MDone : MRun;
        end
    endtask

    // Compare every output against the model, away from the clock edge.
    task automatic compare_all();
        chk("busy", 32'(busy), 32'(m_mode == MRun));
        chk("done", 32'(done), 32'(m_mode == MDone));
        chk("pass", 32'(pass), 32'((m_mode == MDone) && (m_err == 0)));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("first_err", 32'(first_err), 32'(m_first));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("exp_ready", 32'(exp_ready), 32'(model_ready()));
    endtask

    // Caller sets inputs just after a negedge; this checks, clocks the model, returns at next negedge.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        exp_valid = 1'b0;
        obs_valid = 1'b0;
        exp_data  = 2'b00;
        obs_data  = 2'b00;
    endtask

    task automatic do_start(input int n);
        idle_inputs();
        start       = 1'b1;
        num_vectors = CNT_W'(n);
        step();
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] d);
        idle_inputs();
        exp_valid = 1'b1;
        exp_data  = d;
        step();
    endtask

    task automatic send_obs(input logic [1:0] d);
        idle_inputs();
        obs_valid = 1'b1;
        obs_data  = d;
        step();
    endtask

    task automatic literal_result(input string tag, input logic dn, input logic ps,
                                  input int ec, input int fe, input logic uf);
        #1;
        chk({tag, "_done"}, 32'(done), 32'(dn));
        chk({tag, "_pass"}, 32'(pass), 32'(ps));
        chk({tag, "_err"}, 32'(err_count), 32'(ec));
        chk({tag, "_first"}, 32'(first_err), 32'(fe));
        chk({tag, "_uf"}, 32'(underflow), 32'(uf));
    endtask

    logic [1:0] golden[$];

    initial begin
        int budget;
        int gi;
        int n;
        bit acc;
        checks = 0;
        errors = 0;
        rst_n       = 1'b0;
        num_vectors = '0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_first", 32'(first_err), 32'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        step();

        // 1: all vectors match
        do_start(3);
        push_exp(2'b00); push_exp(2'b11); push_exp(2'b00);
        send_obs(2'b00); send_obs(2'b11); send_obs(2'b00);
        idle_inputs(); step();
        literal_result("t1", 1'b1, 1'b1, 0, 255, 1'b0);

        // 2: single mismatch at index 1
        do_start(3);
        push_exp(2'b00); push_exp(2'b11); push_exp(2'b00);
        send_obs(2'b00); send_obs(2'b10); send_obs(2'b00);
        idle_inputs(); step();
        literal_result("t2", 1'b1, 1'b0, 1, 1, 1'b0);

        // 3: observation before any expected vector
        do_start(1);
        send_obs(2'b00);
        idle_inputs(); step();
        literal_result("t3", 1'b1, 1'b0, 1, 0, 1'b1);

        // 4: full FIFO with simultaneous push and pop
        do_start(5);
        push_exp(2'b00); push_exp(2'b01); push_exp(2'b10); push_exp(2'b11);
        idle_inputs();
        exp_valid = 1'b1; exp_data = 2'b01; obs_valid = 1'b1; obs_data = 2'b00;
        #1 chk("t4_ready_full_pop", 32'(exp_ready), 32'd1);
        step();
        idle_inputs();
        exp_valid = 1'b1; exp_data = 2'b10;
        #1 chk("t4_ready_still_full", 32'(exp_ready), 32'd0);
        step();
        send_obs(2'b01); send_obs(2'b10); send_obs(2'b11); send_obs(2'b01);
        idle_inputs(); step();
        literal_result("t4", 1'b1, 1'b1, 0, 255, 1'b0);

        // 5: asynchronous reset mid-run, one entry left buffered
        do_start(4);
        push_exp(2'b01); push_exp(2'b10); push_exp(2'b11);
        send_obs(2'b01); send_obs(2'b00);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_err", 32'(err_count), 32'd0);
        chk("t5_first", 32'(first_err), 32'hFF);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_start(1);
        send_obs(2'b11);
        idle_inputs(); step();
        literal_result("t5_empty", 1'b1, 1'b0, 1, 0, 1'b1);

        // 6: zero-length run and start ignored during RUN
        do_start(0);
        literal_result("t6_zero", 1'b1, 1'b1, 0, 255, 1'b0);
        do_start(3);
        push_exp(2'b10); push_exp(2'b01); push_exp(2'b11);
        send_obs(2'b10);
        idle_inputs(); start = 1'b1; num_vectors = 8'd7; step();
        start = 1'b0;
        send_obs(2'b01); send_obs(2'b11);
        idle_inputs(); step();
        literal_result("t6_run", 1'b1, 1'b1, 0, 255, 1'b0);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 12);
            golden.delete();
            for (int k = 0; k < n + 4; k++) golden.push_back(2'($urandom_range(0, 3)));
            do_start(n);
            gi = 0;
            budget = 300;
            while (m_mode == MRun && budget > 0) begin
                idle_inputs();
                exp_valid = ($urandom_range(0, 3) != 0) && (gi < golden.size());
                exp_data  = (gi < golden.size()) ? golden[gi] : 2'b00;
                obs_valid = ($urandom_range(0, 2) == 0);
                obs_data  = golden[m_idx];
                if ($urandom_range(0, 9) == 0) obs_data = obs_data ^ 2'($urandom_range(1, 3));
                if ($urandom_range(0, 15) == 0) begin
                    start = 1'b1;
                    num_vectors = CNT_W'($urandom_range(0, 20));
                end
                acc = exp_valid && model_ready();
                step();
                if (acc) gi++;
                budget--;
            end
            if (budget == 0) chk("rand_timeout", 32'd1, 32'd0);
            idle_inputs();
            step();
            if ($urandom_range(0, 3) == 0) begin
                obs_valid = 1'b1;
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
